uart_tx_arbiter: RTL and testbench

- Shares the single UART TX FIFO write port between two byte-stream requesters.
  - Requester 0: pipeline-snapshot dump stream from the debug controller.
  - Requester 1: register-file/data-memory dump stream.
- Grants are frame-locked: once a requester is granted, it keeps the port until it delivers its last byte. Frames never interleave on the UART.
- Requesters are selected round-robin.
- A watchdog releases a grant held by a requester that has stalled.

---
 rtl/uart_dbg_pkg.sv | 26 ++
 rtl/arb_watchdog.sv | 52 +++++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_dbg_pkg
// Brief    : Shared arbiter state encoding, requester IDs and frame trailer bytes
// Revision : 1.0
// ============================================================================
package uart_dbg_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic REQ_PIPE = 1'b0;
    localparam logic REQ_MEM  = 1'b1;

    // Both dump streams close their frames with "DONE".
    localparam logic [7:0] TRAILER_D = 8'd68;
    localparam logic [7:0] TRAILER_O = 8'd79;
    localparam logic [7:0] TRAILER_N = 8'd78;
    localparam logic [7:0] TRAILER_E = 8'd69;

    localparam int WDOG_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : arb_watchdog
// Brief    : Stall counter with expiry strobe, one-cycle pulse and saturating
//            forced-release event counter
// Revision : 1.0
// ============================================================================
module arb_watchdog
    import uart_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     advance,
    output logic                     expire,
    output logic                     timeoutPulse,
    output logic [ERR_CNT_WIDTH-1:0] timeoutCount
);

    localparam logic [WDOG_WIDTH-1:0] c_LIMIT = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WDOG_WIDTH-1:0]    r_stallCount;
    logic                     r_pulse;
    logic [ERR_CNT_WIDTH-1:0] r_eventCount;

    assign expire       = advance && (r_stallCount == c_LIMIT);
    assign timeoutPulse = r_pulse;
    assign timeoutCount = r_eventCount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stallCount <= '0;
            r_pulse      <= 1'b0;
            r_eventCount <= '0;
        end else begin
            r_pulse <= expire;
            if (clear || expire) begin
                r_stallCount <= '0;
            end else if (advance) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (expire && (r_eventCount != '1)) begin
                r_eventCount <= r_eventCount + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Frame-locked round-robin arbiter sharing the UART TX FIFO write
//            port between the pipeline-dump and memory-dump streams
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [7:0]               req0_data,
    input  logic                     req0_last,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [7:0]               req1_data,
    input  logic                     req1_last,
    output logic                     req1_ready,
    input  logic                     fifoFull,
    output logic [7:0]               dataToUartOutFifo,
    output logic                     writeFifoFlag,
    output logic [1:0]               grant,
    output logic                     busy,
    output logic                     timeoutPulse,
    output logic [ERR_CNT_WIDTH-1:0] timeoutCount
);

    arb_state_t r_state;
    logic [1:0] r_grant;
    logic       r_busy;
    logic       r_lastServed;

    logic w_xfer0;
    logic w_xfer1;
    logic w_write;
    logic w_lastXfer;
    logic w_ownerValid;
    logic w_advance;
    logic w_clear;
    logic w_expire;

    // Grant is only non-zero while LOCKED, so it alone qualifies ready.
    assign req0_ready    = r_grant[0] & ~fifoFull;
    assign req1_ready    = r_grant[1] & ~fifoFull;
    assign w_xfer0       = req0_valid & req0_ready;
    assign w_xfer1       = req1_valid & req1_ready;
    assign w_write       = w_xfer0 | w_xfer1;
    assign w_lastXfer    = (w_xfer0 & req0_last) | (w_xfer1 & req1_last);
    assign writeFifoFlag = w_write;
    assign grant         = r_grant;
    assign busy          = r_busy;

    always_comb begin
        dataToUartOutFifo = 8'h00;
        if (w_xfer0) begin
            dataToUartOutFifo = req0_data;
        end else if (w_xfer1) begin
            dataToUartOutFifo = req1_data;
        end
    end

    assign w_ownerValid = (r_grant[0] & req0_valid) | (r_grant[1] & req1_valid);
    assign w_advance    = (r_state == LOCKED) & ~w_ownerValid & ~fifoFull;
    assign w_clear      = (r_state == IDLE) | w_write;

    arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .ERR_CNT_WIDTH  (ERR_CNT_WIDTH)
    ) u_watchdog (
        .clock        (clock),
        .reset        (reset),
        .clear        (w_clear),
        .advance      (w_advance),
        .expire       (w_expire),
        .timeoutPulse (timeoutPulse),
        .timeoutCount (timeoutCount)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_lastServed <= REQ_MEM;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req0_valid && (!req1_valid || (r_lastServed == REQ_MEM))) begin
                        r_state <= LOCKED;
                        r_grant <= 2'b01;
                        r_busy  <= 1'b1;
                    end else if (req1_valid) begin
                        r_state <= LOCKED;
                        r_grant <= 2'b10;
                        r_busy  <= 1'b1;
                    end
                end
                LOCKED: begin
                    // A last-byte transfer implies owner valid, so it never
                    // coincides with expiry; both release the same way.
                    if (w_lastXfer || w_expire) begin
                        r_state      <= IDLE;
                        r_grant      <= 2'b00;
                        r_busy       <= 1'b0;
                        r_lastServed <= r_grant[1] ? REQ_MEM : REQ_PIPE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Scenario-per-task bench with a frame-level reference for the arbiter
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_dbg_pkg::*;

    localparam int TO = 8;
    localparam int EW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [7:0]    req0_data = 8'h00;
    logic          req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [7:0]    req1_data = 8'h00;
    logic          fifoFull = 1'b0;
    logic [7:0]    dataToUartOutFifo;
    logic          writeFifoFlag;
    logic [1:0]    grant;
    logic          busy;
    logic          timeoutPulse;
    logic [EW-1:0] timeoutCount;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Pending bytes per requester: bit 8 = last flag.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] obsData[$];
    int         obsCycle[$];
    bit         popped0, popped1, popLast0, popLast1;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(EW)) dut (
        .clock             (clock),
        .reset             (reset),
        .req0_valid        (req0_valid),
        .req0_data         (req0_data),
        .req0_last         (req0_last),
        .req0_ready        (req0_ready),
        .req1_valid        (req1_valid),
        .req1_data         (req1_data),
        .req1_last         (req1_last),
        .req1_ready        (req1_ready),
        .fifoFull          (fifoFull),
        .dataToUartOutFifo (dataToUartOutFifo),
        .writeFifoFlag     (writeFifoFlag),
        .grant             (grant),
        .busy              (busy),
        .timeoutPulse      (timeoutPulse),
        .timeoutCount      (timeoutCount)
    );

    always #5 clock = ~clock;

    // Drive one cycle at the falling edge, then sample mid-cycle.
    task automatic step(input bit full, input bit g0, input bit g1);
        logic [8:0] v;
        @(negedge clock);
        cyc++;
        fifoFull   = full;
        req0_valid = (q0.size() > 0) && !g0;
        req0_data  = 8'h00;
        req0_last  = 1'b0;
        if (q0.size() > 0) begin
            v = q0[0];
            req0_data = v[7:0];
            req0_last = v[8];
        end
        req1_valid = (q1.size() > 0) && !g1;
        req1_data  = 8'h00;
        req1_last  = 1'b0;
        if (q1.size() > 0) begin
            v = q1[0];
            req1_data = v[7:0];
            req1_last = v[8];
        end
        #1;
        popped0 = 1'b0;
        popped1 = 1'b0;
        if (writeFifoFlag) begin
            obsData.push_back(dataToUartOutFifo);
            obsCycle.push_back(cyc);
        end
        if (req0_valid && req0_ready) begin
            v = q0.pop_front();
            popped0 = 1'b1;
            popLast0 = v[8];
        end
        if (req1_valid && req1_ready) begin
            v = q1.pop_front();
            popped1 = 1'b1;
            popLast1 = v[8];
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        fifoFull   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        #2;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (timeoutPulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", timeoutPulse); end
        checks++; if (timeoutCount !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", timeoutCount); end
        checks++; if (writeFifoFlag !== 1'b0 || dataToUartOutFifo !== 8'h00) begin errors++; $display("FAIL reset_write: got flag=%b data=%h want 0/00", writeFifoFlag, dataToUartOutFifo); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready); end
        @(negedge clock);
        reset = 1'b0;
        req0_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] exp[4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        q0 = '{9'h011, 9'h022, 9'h033, 9'h144};
        step(0, 0, 0);
        checks++; if (grant !== 2'b00 || writeFifoFlag !== 1'b0) begin errors++; $display("FAIL single_arb: got grant=%b flag=%b want 00/0", grant, writeFifoFlag); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            checks++; if (grant !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL single_grant[%0d]: got grant=%b busy=%b want 01/1", i, grant, busy); end
            checks++; if (writeFifoFlag !== 1'b1 || dataToUartOutFifo !== exp[i]) begin errors++; $display("FAIL single_byte[%0d]: got flag=%b data=%h want 1/%h", i, writeFifoFlag, dataToUartOutFifo, exp[i]); end
        end
        step(0, 0, 0);
        checks++; if (grant !== 2'b00 || busy !== 1'b0 || writeFifoFlag !== 1'b0) begin errors++; $display("FAIL single_release: got grant=%b busy=%b flag=%b want 00/0/0", grant, busy, writeFifoFlag); end
    endtask

    task automatic test_contention();
        logic [7:0] exp[4];
        int base;
        exp = '{TRAILER_D, TRAILER_O, TRAILER_N, TRAILER_E};
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            base = obsData.size();
            q0 = '{{1'b0, TRAILER_D}, {1'b1, TRAILER_O}};
            q1 = '{{1'b0, TRAILER_N}, {1'b1, TRAILER_E}};
            repeat (8) step(0, 0, 0);
            checks++;
            if (obsData.size() - base != 4) begin
                errors++; $display("FAIL contention_count[%0d]: got %0d writes want 4", rep, obsData.size() - base);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    checks++; if (obsData[base+i] !== exp[i]) begin errors++; $display("FAIL contention_order[%0d][%0d]: got %h want %h", rep, i, obsData[base+i], exp[i]); end
                end
                checks++; if (obsCycle[base+1] - obsCycle[base] != 1 || obsCycle[base+2] - obsCycle[base+1] != 2) begin
                    errors++; $display("FAIL contention_timing[%0d]: got gaps %0d,%0d want 1,2", rep, obsCycle[base+1] - obsCycle[base], obsCycle[base+2] - obsCycle[base+1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[6];
        int base;
        base = obsData.size();
        for (int i = 0; i < 6; i++) begin
            exp[i] = 8'($urandom);
            q0.push_back({(i == 5), exp[i]});
        end
        for (int k = 0; k < 10 && (obsData.size() - base) < 2; k++) step(0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0);
            checks++; if (req0_ready !== 1'b0 || writeFifoFlag !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL bp_full[%0d]: got ready=%b flag=%b grant=%b want 0/0/01", k, req0_ready, writeFifoFlag, grant); end
        end
        // Stalled and full: must not count toward the watchdog.
        for (int k = 0; k < 12; k++) begin
            step(1, 1, 0);
            checks++; if (grant !== 2'b01 || timeoutPulse !== 1'b0) begin errors++; $display("FAIL bp_full_stall[%0d]: got grant=%b pulse=%b want 01/0", k, grant, timeoutPulse); end
        end
        for (int k = 0; k < TO - 1; k++) begin
            step(0, 1, 0);
            checks++; if (grant !== 2'b01 || timeoutPulse !== 1'b0) begin errors++; $display("FAIL bp_stall[%0d]: got grant=%b pulse=%b want 01/0", k, grant, timeoutPulse); end
        end
        for (int k = 0; k < 20 && q0.size() > 0; k++) step(0, 0, 0);
        step(0, 0, 0);
        checks++;
        if (obsData.size() - base != 6) begin
            errors++; $display("FAIL bp_count: got %0d writes want 6", obsData.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (obsData[base+i] !== exp[i]) begin errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, obsData[base+i], exp[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        q1 = '{9'h05A};
        step(0, 0, 0);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_arb: got grant=%b want 00", grant); end
        step(0, 0, 0);
        checks++; if (grant !== 2'b10 || writeFifoFlag !== 1'b1 || dataToUartOutFifo !== 8'h5A) begin errors++; $display("FAIL to_byte: got grant=%b flag=%b data=%h want 10/1/5a", grant, writeFifoFlag, dataToUartOutFifo); end
        for (int k = 0; k < TO; k++) begin
            step(0, 0, 0);
            checks++; if (grant !== 2'b10 || timeoutPulse !== 1'b0) begin errors++; $display("FAIL to_hold[%0d]: got grant=%b pulse=%b want 10/0", k, grant, timeoutPulse); end
        end
        q0 = '{9'h1C3};
        q1 = '{9'h13C};
        step(0, 0, 0);
        checks++; if (grant !== 2'b00 || busy !== 1'b0 || timeoutPulse !== 1'b1) begin errors++; $display("FAIL to_release: got grant=%b busy=%b pulse=%b want 00/0/1", grant, busy, timeoutPulse); end
        checks++; if (timeoutCount !== 2'd1) begin errors++; $display("FAIL to_count: got %0d want 1", timeoutCount); end
        step(0, 0, 0);
        checks++; if (grant !== 2'b01 || timeoutPulse !== 1'b0 || dataToUartOutFifo !== 8'hC3) begin errors++; $display("FAIL to_next: got grant=%b pulse=%b data=%h want 01/0/c3", grant, timeoutPulse, dataToUartOutFifo); end
        step(0, 0, 0);
        step(0, 0, 0);
        checks++; if (grant !== 2'b10 || dataToUartOutFifo !== 8'h3C) begin errors++; $display("FAIL to_other: got grant=%b data=%h want 10/3c", grant, dataToUartOutFifo); end
        repeat (2) step(0, 0, 0);
    endtask

    task automatic test_reset_midframe();
        int base;
        q0 = '{9'h1A5};
        repeat (3) step(0, 0, 0);
        q1 = '{9'h0B0, 9'h0B1, 9'h0B2, 9'h0B3, 9'h1B4};
        base = obsData.size();
        for (int k = 0; k < 10 && (obsData.size() - base) < 2; k++) step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b1;
        #1;
        checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_grant: got grant=%b busy=%b want 00/0", grant, busy); end
        checks++; if (writeFifoFlag !== 1'b0 || dataToUartOutFifo !== 8'h00 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_write: got flag=%b data=%h ready=%b want 0/00/0", writeFifoFlag, dataToUartOutFifo, req1_ready); end
        checks++; if (timeoutCount !== '0) begin errors++; $display("FAIL rst_mid_count: got %0d want 0", timeoutCount); end
        q0.delete();
        q1.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        q0 = '{9'h161};
        q1 = '{9'h162};
        base = obsData.size();
        repeat (5) step(0, 0, 0);
        checks++;
        if (obsData.size() - base != 2 || obsData[base] !== 8'h61) begin
            errors++; $display("FAIL rst_mid_prio: got %0d writes first=%h want 2/61", obsData.size() - base, (obsData.size() > base) ? obsData[base] : 8'h00);
        end
    endtask

    task automatic test_saturation();
        bit seen;
        logic [EW-1:0] expCnt;
        for (int t = 1; t <= 5; t++) begin
            q0 = '{9'h077};
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                step(0, 0, 0);
                if (timeoutPulse === 1'b1) seen = 1'b1;
            end
            expCnt = (t > 3) ? 2'd3 : EW'(t);
            checks++; if (!seen) begin errors++; $display("FAIL sat_pulse[%0d]: got no pulse within 40 cycles want pulse", t); end
            checks++; if (timeoutCount !== expCnt) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", t, timeoutCount, expCnt); end
            step(0, 0, 0);
        end
    endtask

    // Both streams always have a frame pending at arbitration, so the output
    // must be a strict A/B alternation of whole frames starting with A.
    task automatic test_random();
        logic [7:0] exp[$];
        int base, len, gr0, gr1, n;
        bit in0, in1, g0, g1, full;
        do_reset();
        base = obsData.size();
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                exp.push_back(8'($urandom));
                q0.push_back({(i == len - 1), exp[exp.size()-1]});
            end
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                exp.push_back(8'($urandom));
                q1.push_back({(i == len - 1), exp[exp.size()-1]});
            end
        end
        in0 = 0; in1 = 0; gr0 = 0; gr1 = 0;
        for (int c = 0; c < 1500 && (q0.size() > 0 || q1.size() > 0); c++) begin
            g0 = in0 && gr0 < 3 && ($urandom_range(3) == 0);
            g1 = in1 && gr1 < 3 && ($urandom_range(3) == 0);
            gr0 = g0 ? gr0 + 1 : 0;
            gr1 = g1 ? gr1 + 1 : 0;
            full = ($urandom_range(3) == 0);
            step(full, g0, g1);
            if (popped0) in0 = !popLast0;
            if (popped1) in1 = !popLast1;
            checks++;
            if ((!writeFifoFlag && dataToUartOutFifo !== 8'h00) || (fifoFull && writeFifoFlag) || timeoutPulse !== 1'b0 || busy !== (grant != 2'b00)) begin
                errors++; $display("FAIL rand_cycle[%0d]: got flag=%b data=%h full=%b pulse=%b busy=%b grant=%b", c, writeFifoFlag, dataToUartOutFifo, fifoFull, timeoutPulse, busy, grant);
            end
        end
        repeat (3) step(0, 0, 0);
        n = obsData.size() - base;
        checks++; if (n != exp.size()) begin errors++; $display("FAIL rand_count: got %0d writes want %0d", n, exp.size()); end
        for (int i = 0; i < n && i < exp.size(); i++) begin
            checks++; if (obsData[base+i] !== exp[i]) begin errors++; $display("FAIL rand_byte[%0d]: got %h want %h", i, obsData[base+i], exp[i]); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_midframe();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
